// File: rtl/bram2axis_pkg.sv
// Shared types, constants and helpers for the BRAM-to-AXIS packer.
// Optional TKEEP output is enabled with the B2A_TKEEP_EN macro.
package bram2axis_pkg;

    // Reference configuration; modules re-derive these from their own parameters.
    localparam int DEF_AXIS_W = 64;
    localparam int DEF_BRAM_W = 32;
    localparam int OCC_W      = 5;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int RATIO     = DEF_AXIS_W / DEF_BRAM_W;
    localparam int LANE_BITS = (RATIO > 1) ? clogb2(RATIO) : 1;

    typedef enum logic [1:0] {IDLE, READ, SEND} drain_state_t;

    function automatic bit cfg_ok(input int axis_w, input int bram_w, input int depth,
                                  input int aw, input int mb);
        bit ok;
        int ratio;
        ok    = 1'b1;
        ratio = 0;
        if (bram_w < 8 || (bram_w % 8) != 0) begin
            ok = 1'b0;
        end else begin
            if (axis_w < bram_w || (axis_w % bram_w) != 0) ok = 1'b0;
            ratio = axis_w / bram_w;
            if ((ratio & (ratio - 1)) != 0) ok = 1'b0;
        end
        if (depth < 1 || aw < 1 || aw > 30 || (1 << aw) < depth) ok = 1'b0;
        if (mb < 1 || mb > 16) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bram2axis_packer_ring.sv
// Buffer ring bookkeeping: fill/drain pointers, occupancy, per-buffer
// frame lengths, and the ready/overflow status flags.
module mb_ring_ctrl
    import bram2axis_pkg::*;
#(
    parameter int C_MB_DEPTH        = 2,
    parameter int C_BRAM_DATA_DEPTH = 1024,
    parameter int LEN_W             = 11,
    parameter int PTR_W             = 1
) (
    input  logic             ACC_CLK,
    input  logic             ARESETN,
    input  logic             i_commit,
    input  logic [LEN_W-1:0] i_acc_len,
    input  logic             i_release,
    output logic [PTR_W-1:0] o_fill_ptr,
    output logic [PTR_W-1:0] o_drain_ptr,
    output logic [OCC_W-1:0] o_occ,
    output logic [LEN_W-1:0] o_drain_len,
    output logic             o_ready,
    output logic             o_overflow
);

    logic [PTR_W-1:0] r_fill_ptr, r_drain_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [LEN_W-1:0] r_lens [C_MB_DEPTH];
    logic             r_ready, r_overflow;

    logic             w_full, w_commit;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [LEN_W-1:0] w_len_clamped;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(C_MB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full        = (r_occ == OCC_W'(C_MB_DEPTH));
    assign w_commit      = i_commit && !w_full;
    assign w_occ_nxt     = r_occ + OCC_W'(w_commit) - OCC_W'(i_release);
    assign w_len_clamped = (i_acc_len > LEN_W'(C_BRAM_DATA_DEPTH)) ? LEN_W'(C_BRAM_DATA_DEPTH)
                                                                   : i_acc_len;

    always_ff @(posedge ACC_CLK) begin
        if (!ARESETN) begin
            r_fill_ptr  <= '0;
            r_drain_ptr <= '0;
            r_occ       <= '0;
            r_ready     <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            if (w_commit)  r_fill_ptr  <= ptr_inc(r_fill_ptr);
            if (i_release) r_drain_ptr <= ptr_inc(r_drain_ptr);
            r_occ   <= w_occ_nxt;
            r_ready <= (w_occ_nxt < OCC_W'(C_MB_DEPTH));
            // Commits into a full ring are dropped; the flag stays until reset.
            if (i_commit && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge ACC_CLK) begin
        if (w_commit) r_lens[r_fill_ptr] <= w_len_clamped;
    end

    assign o_fill_ptr  = r_fill_ptr;
    assign o_drain_ptr = r_drain_ptr;
    assign o_occ       = r_occ;
    assign o_drain_len = r_lens[r_drain_ptr];
    assign o_ready     = r_ready;
    assign o_overflow  = r_overflow;

endmodule

// File: rtl/bram2axis_packer.sv
// Multi-buffered BRAM-to-AXIS adapter packing RATIO words per beat.
// Define B2A_TKEEP_EN to add the AXIS_TKEEP byte-qualifier output.
module bram2axis_packer
    import bram2axis_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_BRAM_DATA_WIDTH = 32,
    parameter int C_BRAM_DATA_DEPTH = 1024,
    parameter int C_BRAM_ADDR_WIDTH = 10,
    parameter int C_MB_DEPTH        = 2
) (
    input  logic                           ACC_CLK,
    input  logic                           ARESETN,
    input  logic                           CTRL_ACC_DONE,
    input  logic [C_BRAM_ADDR_WIDTH:0]     ACC_LEN,
    output logic                           CTRL_READY,
    output logic                           CTRL_OVERFLOW,
    output logic [OCC_W-1:0]               STATUS_OCC,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]   bram_addr,
    input  logic [C_BRAM_DATA_WIDTH-1:0]   bram_din,
    output logic [C_BRAM_DATA_WIDTH-1:0]   bram_dout,
    input  logic [C_BRAM_DATA_WIDTH/8-1:0] bram_we,
    input  logic                           bram_en,
    output logic [C_AXIS_DATA_WIDTH-1:0]   AXIS_TDATA,
    output logic                           AXIS_TVALID,
    input  logic                           AXIS_TREADY,
    output logic                           AXIS_TLAST
`ifdef B2A_TKEEP_EN
    ,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] AXIS_TKEEP
`endif
);

    localparam int AW          = C_BRAM_ADDR_WIDTH;
    localparam int BW          = C_BRAM_DATA_WIDTH;
    localparam int BYTES       = BW / 8;
    localparam int L_RATIO     = C_AXIS_DATA_WIDTH / C_BRAM_DATA_WIDTH;
    localparam int L_LANE_BITS = (L_RATIO > 1) ? clogb2(L_RATIO) : 1;
    localparam int PTR_W       = (C_MB_DEPTH > 1) ? clogb2(C_MB_DEPTH) : 1;
    localparam int LEN_W       = AW + 1;
    localparam int MEM_AW      = PTR_W + AW;

    if (!cfg_ok(C_AXIS_DATA_WIDTH, C_BRAM_DATA_WIDTH, C_BRAM_DATA_DEPTH, C_BRAM_ADDR_WIDTH,
                C_MB_DEPTH)) begin : g_bad_cfg
        $error("bram2axis_packer: illegal parameter combination");
    end

    logic [PTR_W-1:0] w_fill_ptr, w_drain_ptr;
    logic [OCC_W-1:0] w_occ;
    logic [LEN_W-1:0] w_drain_len;
    logic             w_release, w_issue, w_latch, w_hs, w_idx_last;
    logic [L_LANE_BITS-1:0] w_lane;
    logic [MEM_AW-1:0] w_a_addr, w_b_addr;

    mb_ring_ctrl #(
        .C_MB_DEPTH        (C_MB_DEPTH),
        .C_BRAM_DATA_DEPTH (C_BRAM_DATA_DEPTH),
        .LEN_W             (LEN_W),
        .PTR_W             (PTR_W)
    ) u_ring (
        .ACC_CLK     (ACC_CLK),
        .ARESETN     (ARESETN),
        .i_commit    (CTRL_ACC_DONE),
        .i_acc_len   (ACC_LEN),
        .i_release   (w_release),
        .o_fill_ptr  (w_fill_ptr),
        .o_drain_ptr (w_drain_ptr),
        .o_occ       (w_occ),
        .o_drain_len (w_drain_len),
        .o_ready     (CTRL_READY),
        .o_overflow  (CTRL_OVERFLOW)
    );

    // Buffer index sits above the word address, so each buffer owns a 2**AW slice.
    logic [BW-1:0] r_mem [0:(1 << MEM_AW)-1];
    logic [BW-1:0] r_dout, r_q;

    drain_state_t r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len, r_rd_idx;
    logic             r_issue_done, r_rd_vld, r_last;
    logic [L_LANE_BITS-1:0] r_rd_lane;
    logic [L_RATIO-1:0][BW-1:0] r_lanes;
`ifdef B2A_TKEEP_EN
    logic [L_RATIO-1:0][BYTES-1:0] r_keep;
`endif

    assign w_a_addr = {w_fill_ptr, bram_addr};
    assign w_b_addr = {w_drain_ptr, r_rd_idx[AW-1:0]};

    always_ff @(posedge ACC_CLK) begin
        if (bram_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bram_we[b]) r_mem[w_a_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            end
            r_dout <= r_mem[w_a_addr];
        end
    end

    always_ff @(posedge ACC_CLK) begin
        if (w_issue) r_q <= r_mem[w_b_addr];
    end

    assign bram_dout = r_dout;

    always_ff @(posedge ACC_CLK) begin
        if (!ARESETN) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_latch     = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_occ != '0) begin
                    // Empty frames are retired without touching the stream.
                    if (w_drain_len == '0) begin
                        w_release = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (r_issue_done) w_state_nxt = SEND;
                else              w_issue     = 1'b1;
            end
            SEND: begin
                if (AXIS_TREADY) begin
                    w_state_nxt = r_last ? IDLE : READ;
                    w_release   = r_last;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_hs       = (r_state == SEND) && AXIS_TREADY;
    assign w_lane     = L_LANE_BITS'(r_rd_idx & LEN_W'(L_RATIO - 1));
    assign w_idx_last = (r_rd_idx == r_len - LEN_W'(1));

    always_ff @(posedge ACC_CLK) begin
        if (!ARESETN) begin
            r_len        <= '0;
            r_rd_idx     <= '0;
            r_issue_done <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_lane    <= '0;
            r_lanes      <= '0;
            r_last       <= 1'b0;
`ifdef B2A_TKEEP_EN
            r_keep       <= '0;
`endif
        end else begin
            r_rd_vld  <= w_issue;
            r_rd_lane <= w_lane;
            if (w_latch) begin
                r_len        <= w_drain_len;
                r_rd_idx     <= '0;
                r_issue_done <= 1'b0;
                r_last       <= 1'b0;
            end
            if (w_issue) begin
                r_rd_idx <= r_rd_idx + LEN_W'(1);
                if (w_lane == L_LANE_BITS'(L_RATIO - 1) || w_idx_last) r_issue_done <= 1'b1;
                if (w_idx_last) r_last <= 1'b1;
            end
            // RAM data lands one cycle after its read was issued.
            if (r_rd_vld) begin
                r_lanes[r_rd_lane] <= r_q;
`ifdef B2A_TKEEP_EN
                r_keep[r_rd_lane]  <= '1;
`endif
            end
            if (w_hs) begin
                r_lanes      <= '0;
                r_issue_done <= 1'b0;
                r_last       <= 1'b0;
`ifdef B2A_TKEEP_EN
                r_keep       <= '0;
`endif
            end
        end
    end

    assign STATUS_OCC  = w_occ;
    assign AXIS_TDATA  = r_lanes;
    assign AXIS_TVALID = (r_state == SEND);
    assign AXIS_TLAST  = (r_state == SEND) && r_last;
`ifdef B2A_TKEEP_EN
    assign AXIS_TKEEP  = r_keep;
`endif

endmodule

// File: tb/tb_bram2axis_packer.sv
// Scoreboard bench for bram2axis_packer in its default configuration.
module tb_bram2axis_packer;
    import bram2axis_pkg::*;

    localparam int AW = 10;
    localparam int BW = 32;
    localparam int XW = 64;

    logic            ACC_CLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            CTRL_ACC_DONE = 1'b0;
    logic [AW:0]     ACC_LEN = '0;
    logic            CTRL_READY, CTRL_OVERFLOW;
    logic [4:0]      STATUS_OCC;
    logic [AW-1:0]   bram_addr = '0;
    logic [BW-1:0]   bram_din = '0;
    logic [BW-1:0]   bram_dout;
    logic [BW/8-1:0] bram_we = '0;
    logic            bram_en = 1'b0;
    logic [XW-1:0]   AXIS_TDATA;
    logic            AXIS_TVALID, AXIS_TLAST;
    logic            AXIS_TREADY = 1'b0;
`ifdef B2A_TKEEP_EN
    logic [XW/8-1:0] AXIS_TKEEP;
`endif

    always #5 ACC_CLK = ~ACC_CLK;

    bram2axis_packer dut (
        .ACC_CLK       (ACC_CLK),
        .ARESETN       (ARESETN),
        .CTRL_ACC_DONE (CTRL_ACC_DONE),
        .ACC_LEN       (ACC_LEN),
        .CTRL_READY    (CTRL_READY),
        .CTRL_OVERFLOW (CTRL_OVERFLOW),
        .STATUS_OCC    (STATUS_OCC),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_dout     (bram_dout),
        .bram_we       (bram_we),
        .bram_en       (bram_en),
        .AXIS_TDATA    (AXIS_TDATA),
        .AXIS_TVALID   (AXIS_TVALID),
        .AXIS_TREADY   (AXIS_TREADY),
        .AXIS_TLAST    (AXIS_TLAST)
`ifdef B2A_TKEEP_EN
        ,
        .AXIS_TKEEP    (AXIS_TKEEP)
`endif
    );

    typedef struct {
        logic [XW-1:0]   data;
        logic            last;
        logic [XW/8-1:0] keep;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            beats_seen = 0;
    logic [XW-1:0] last_tdata = '0;
    bit            thr_done = 1'b0;

    // Output monitor: scoreboard pop on handshake, hold-stability while stalled.
    initial begin
        bit            prev_hold;
        logic [XW-1:0] prev_data;
        logic          prev_last;
        beat_t         e;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge ACC_CLK);
            if (!ARESETN) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== prev_data || AXIS_TLAST !== prev_last) begin
                        errors++;
                        $display("FAIL hold_stable tvalid=%b data=%h last=%b required tvalid=1 data=%h last=%b",
                                 AXIS_TVALID, AXIS_TDATA, AXIS_TLAST, prev_data, prev_last);
                    end
                end
                if (AXIS_TVALID && AXIS_TREADY) begin
                    beats_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat data=%h last=%b required no beat", AXIS_TDATA, AXIS_TLAST);
                    end else begin
                        e = exp_q.pop_front();
                        if (AXIS_TDATA !== e.data || AXIS_TLAST !== e.last) begin
                            errors++;
                            $display("FAIL beat data=%h last=%b required data=%h last=%b",
                                     AXIS_TDATA, AXIS_TLAST, e.data, e.last);
                        end
`ifdef B2A_TKEEP_EN
                        checks++;
                        if (AXIS_TKEEP !== e.keep) begin
                            errors++;
                            $display("FAIL tkeep got=%h required=%h", AXIS_TKEEP, e.keep);
                        end
`endif
                    end
                    if (AXIS_TLAST) last_tdata = AXIS_TDATA;
                end
                prev_hold = AXIS_TVALID && !AXIS_TREADY;
                prev_data = AXIS_TDATA;
                prev_last = AXIS_TLAST;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACC_CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [BW-1:0] d);
        bram_en   = 1'b1;
        bram_we   = '1;
        bram_addr = AW'(a);
        bram_din  = d;
        tick();
        bram_en   = 1'b0;
        bram_we   = '0;
    endtask

    task automatic push_exp(input int len, input logic [BW-1:0] base);
        int    nb;
        int    idx;
        beat_t e;
        nb = (len + RATIO - 1) / RATIO;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < RATIO; l++) begin
                idx = b * RATIO + l;
                if (idx < len) begin
                    e.data[l*BW +: BW]       = base + BW'(idx);
                    e.keep[l*BW/8 +: BW/8]   = '1;
                end
            end
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!CTRL_READY && c < 1000) begin
            tick();
            c++;
        end
        if (c >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_ready timeout ctrl_ready=%b required 1", CTRL_READY);
        end
    endtask

    task automatic send_frame(input int len, input logic [BW-1:0] base, input bit do_write,
                              input bit accept);
        if (do_write) begin
            wait_ready();
            for (int i = 0; i < len; i++) wr(i, base + BW'(i));
        end
        if (accept) push_exp(len, base);
        CTRL_ACC_DONE = 1'b1;
        ACC_LEN       = (AW + 1)'(len);
        tick();
        CTRL_ACC_DONE = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || STATUS_OCC != 0 || AXIS_TVALID) && c < 2000) begin
            tick();
            c++;
        end
        checks++;
        if (exp_q.size() != 0 || STATUS_OCC !== 5'd0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d occ=%0d required pending=0 occ=0", tag, exp_q.size(), STATUS_OCC);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (CTRL_READY !== 1'b1)    begin errors++; $display("FAIL rst_ready got=%b required=1", CTRL_READY); end
        if (CTRL_OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b required=0", CTRL_OVERFLOW); end
        if (STATUS_OCC !== 5'd0)    begin errors++; $display("FAIL rst_occ got=%0d required=0", STATUS_OCC); end
        if (AXIS_TVALID !== 1'b0)   begin errors++; $display("FAIL rst_tvalid got=%b required=0", AXIS_TVALID); end
        if (AXIS_TLAST !== 1'b0)    begin errors++; $display("FAIL rst_tlast got=%b required=0", AXIS_TLAST); end
        if (AXIS_TDATA !== '0)      begin errors++; $display("FAIL rst_tdata got=%h required=0", AXIS_TDATA); end
        ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int c;
        AXIS_TREADY = 1'b0;
        send_frame(8, 32'd1, 1'b1, 1'b1);
        checks++;
        if (STATUS_OCC !== 5'd1) begin errors++; $display("FAIL basic_occ got=%0d required=1", STATUS_OCC); end
        c = 0;
        while (!AXIS_TVALID && c < 50) begin
            tick();
            c++;
        end
        checks++;
        if (c != RATIO + 2) begin
            errors++;
            $display("FAIL basic_latency got=%0d required=%0d", c, RATIO + 2);
        end
        tick();
        AXIS_TREADY = 1'b1;
        wait_drain("basic");
    endtask

    task automatic test_partial();
        AXIS_TREADY = 1'b1;
        send_frame(5, 32'd1, 1'b1, 1'b1);
        wait_drain("partial");
        checks++;
        if (last_tdata !== 64'h0000_0000_0000_0005) begin
            errors++;
            $display("FAIL partial_last got=%h required=%h", last_tdata, 64'h5);
        end
    endtask

    task automatic test_overflow();
        AXIS_TREADY = 1'b0;
        send_frame(4, 32'h100, 1'b1, 1'b1);
        checks++;
        if (CTRL_READY !== 1'b1) begin errors++; $display("FAIL ovf_ready1 got=%b required=1", CTRL_READY); end
        send_frame(2, 32'h200, 1'b1, 1'b1);
        checks += 2;
        if (CTRL_READY !== 1'b0)    begin errors++; $display("FAIL ovf_ready2 got=%b required=0", CTRL_READY); end
        if (CTRL_OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b required=0", CTRL_OVERFLOW); end
        send_frame(4, 32'h300, 1'b0, 1'b0);
        checks += 2;
        if (CTRL_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b required=1", CTRL_OVERFLOW); end
        if (STATUS_OCC !== 5'd2)    begin errors++; $display("FAIL ovf_occ got=%0d required=2", STATUS_OCC); end
        AXIS_TREADY = 1'b1;
        wait_drain("ovf");
        checks += 2;
        if (CTRL_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b required=1", CTRL_OVERFLOW); end
        if (CTRL_READY !== 1'b1)    begin errors++; $display("FAIL ovf_ready3 got=%b required=1", CTRL_READY); end
    endtask

    task automatic test_zero_len();
        int b0;
        AXIS_TREADY = 1'b1;
        b0 = beats_seen;
        send_frame(0, 32'h0, 1'b0, 1'b1);
        send_frame(2, 32'h400, 1'b1, 1'b1);
        wait_drain("zero");
        checks++;
        if (beats_seen - b0 != 1) begin
            errors++;
            $display("FAIL zero_beats got=%0d required=1", beats_seen - b0);
        end
    endtask

    task automatic test_throttle();
        int lens[4] = '{3, 6, 1, 7};
        thr_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(lens[f], 32'hA000_0000 + BW'(f * 256), 1'b1, 1'b1);
                thr_done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!thr_done && n < 5000) begin
                    AXIS_TREADY = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
            end
        join
        repeat (40) begin
            AXIS_TREADY = 1'($urandom_range(0, 1));
            tick();
        end
        AXIS_TREADY = 1'b1;
        wait_drain("throttle");
    endtask

    task automatic test_reset_midframe();
        int c;
        int b0;
        AXIS_TREADY = 1'b0;
        b0 = beats_seen;
        send_frame(8, 32'h500, 1'b1, 1'b1);
        c = 0;
        while (!AXIS_TVALID && c < 50) begin tick(); c++; end
        AXIS_TREADY = 1'b1;
        tick();
        AXIS_TREADY = 1'b0;
        c = 0;
        while (!AXIS_TVALID && c < 50) begin tick(); c++; end
        checks++;
        if (!AXIS_TVALID || beats_seen - b0 != 1) begin
            errors++;
            $display("FAIL midrst_beat2 tvalid=%b beats=%0d required tvalid=1 beats=1", AXIS_TVALID, beats_seen - b0);
        end
        ARESETN = 1'b0;
        @(posedge ACC_CLK);
        @(negedge ACC_CLK);
        checks += 4;
        if (AXIS_TVALID !== 1'b0)   begin errors++; $display("FAIL midrst_tvalid got=%b required=0", AXIS_TVALID); end
        if (STATUS_OCC !== 5'd0)    begin errors++; $display("FAIL midrst_occ got=%0d required=0", STATUS_OCC); end
        if (CTRL_OVERFLOW !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b required=0", CTRL_OVERFLOW); end
        if (AXIS_TDATA !== '0)      begin errors++; $display("FAIL midrst_tdata got=%h required=0", AXIS_TDATA); end
        ARESETN = 1'b1;
        exp_q.delete();
        tick();
        AXIS_TREADY = 1'b1;
        send_frame(3, 32'h600, 1'b1, 1'b1);
        wait_drain("postrst");
        checks++;
        if (last_tdata !== 64'h0000_0000_0000_0602) begin
            errors++;
            $display("FAIL postrst_last got=%h required=%h", last_tdata, 64'h602);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_zero_len();
        test_throttle();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
